line_fetch_ctrl: RTL and testbench
==================================

// Module: line_fetch_ctrl
// PURPOSE
// - Parametrised line-buffer fill engine: on request, fetches one tile-line (WIDTH_PX/TILE_WIDTH tiles)
//   from the frame buffer over the rd_req/rd_rsp handshake and unpacks it into one of NUM_BUFFS line buffers.
// - Sits between the line buffer controller (issues fetch requests) and frame_buffer / line buffer RAMs.
// - Generalises the two-buffer fill path to N buffers, arbitrary tiles per memory row, optional rsp timeout.
// PARAMETERS
// - PXL_WIDTH        12    bits per tile/pixel (3 x 4-bit colour)
// - TILE_WIDTH       4     tile edge in pixels (n x n tiles)
// - WIDTH_PX         640   display width in pixels
// - HEIGHT_LNS       480   display height in lines
// - TILE_PER_ROW     4     tiles packed per frame-buffer row; must divide WIDTH_PX/TILE_WIDTH
// - NUM_BUFFS        2     number of line buffers, 2..4
// - FBUFF_ADDR_WIDTH 13    frame-buffer address width
// - TIMEOUT_CYC      64    rd_rsp watchdog limit (used only with LINE_FETCH_TIMEOUT_EN)
// - Derived: TILE_PER_LINE=WIDTH_PX/TILE_WIDTH (160); ROWS_PER_LINE=TILE_PER_LINE/TILE_PER_ROW (40);
//   TILE_LNS=HEIGHT_LNS/TILE_WIDTH (120); FBUFF_DATA_WIDTH=TILE_PER_ROW*PXL_WIDTH (48)
// PORTS
// - clk_i           in   1                        pixel clock
// - rst_i           in   1                        asynchronous reset, active-high
// - fetch_req_i     in   1                        1-cycle fetch request pulse
// - tile_ln_i       in   $clog2(TILE_LNS)         tile-line index to fetch
// - buff_id_i       in   $clog2(NUM_BUFFS)        target line buffer
// - fetch_busy_o    out  1                        fetch in progress
// - fetch_done_o    out  1                        1-cycle pulse, line fully written
// - fetch_err_o     out  1                        1-cycle pulse, fetch aborted (timeout)
// - fbuff_rd_req_o  out  1                        frame-buffer read request
// - fbuff_rd_rsp_i  in   1                        frame-buffer read response, data valid
// - fbuff_addr_o    out  FBUFF_ADDR_WIDTH         frame-buffer row address
// - fbuff_data_i    in   FBUFF_DATA_WIDTH         frame-buffer row data
// - lbuff_wen_o     out  NUM_BUFFS                one-hot line-buffer write enable
// - lbuff_addr_o    out  $clog2(TILE_PER_LINE)    tile index within line
// - lbuff_data_o    out  PXL_WIDTH                tile value written
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-fetch aborts immediately; partial buffer contents undefined, no done/err.
// - FSM IDLE -> RD -> UNPK -> (RD | DONE) -> IDLE.
// - IDLE: on fetch_req_i with tile_ln_i < TILE_LNS latch tile_ln_i/buff_id_i, base=tile_ln_i*ROWS_PER_LINE,
//   row=0, busy=1, go RD. tile_ln_i >= TILE_LNS or buff_id_i >= NUM_BUFFS: request ignored.
// - RD: rd_req_o=1, addr_o=base+row held stable until rd_rsp_i sampled high (same-cycle rsp allowed);
//   on rsp capture fbuff_data_i into row register, go UNPK; rd_req_o low next cycle.
// - UNPK: TILE_PER_ROW cycles, cycle k writes tile k = data[k*PXL_WIDTH +: PXL_WIDTH],
//   lbuff_addr_o=row*TILE_PER_ROW+k, lbuff_wen_o=1<<buff. Last k: row<ROWS_PER_LINE-1 -> row++, RD; else DONE.
// - DONE: fetch_done_o=1 one cycle, busy=0, -> IDLE. Next request accepted in IDLE (cycle after DONE).
// - fetch_req_i while busy ignored (no queue). rd_rsp_i outside RD ignored.
// - Zero-wait latency: req to done = ROWS_PER_LINE*(1+TILE_PER_ROW)+1 cycles (201 default).
// - lbuff_wen_o is 0 outside UNPK; lbuff_data_o/addr_o 0 when not writing.
// CONFIGURATION
// - LINE_FETCH_TIMEOUT_EN defined: wait counter in RD; reaching TIMEOUT_CYC cycles without rsp ->
//   rd_req_o low, fetch_err_o pulse 1 cycle, busy=0, IDLE, no fetch_done_o. Counter clears per row.
// - Undefined: RD waits indefinitely; fetch_err_o tied 0; TIMEOUT_CYC unused.
// TESTING
// - Reset: rst_i=1 mid-traffic -> every output 0 within same cycle; busy=0.
// - tile_ln 0, buff 0, rsp same cycle as req, row r holds tiles 4r..4r+3 -> addr_o 0..39, 160 writes addr 0..159, wen=01, done at cycle 201.
// - tile_ln 119, buff 1, rsp delayed 3 cycles -> addr_o 4760..4799 held stable per wait, wen=10 only, one done pulse.
// - fetch_req during busy, and tile_ln 120 in IDLE -> both ignored; exactly one done, no extra rd_req.
// - rst_i pulsed at row 10, then new request tile_ln 5 -> first addr_o 200, full clean line, done once.
// - LINE_FETCH_TIMEOUT_EN: rsp withheld at row 3 -> err pulse after 64 cycles, no done; next fetch completes normally.

Source files
------------

// File: rtl/line_fetch_ctrl_if.sv
// Bundle of request, frame-buffer and line-buffer signals for line_fetch_ctrl.
// master = fill engine side, slave = surrounding system (requester, frame buffer, line RAMs).
interface line_fetch_ctrl_if #(
  parameter int PXL_WIDTH        = 12,
  parameter int TILE_WIDTH       = 4,
  parameter int WIDTH_PX         = 640,
  parameter int HEIGHT_LNS       = 480,
  parameter int TILE_PER_ROW     = 4,
  parameter int NUM_BUFFS        = 2,
  parameter int FBUFF_ADDR_WIDTH = 13
);
  localparam int TILE_PER_LINE    = WIDTH_PX / TILE_WIDTH;
  localparam int TILE_LNS         = HEIGHT_LNS / TILE_WIDTH;
  localparam int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH;

  // Handshakes: fetch_req_i is a one-cycle pulse, honoured only while idle.
  // fbuff_rd_req_o/fbuff_addr_o stay stable until a cycle where fbuff_rd_rsp_i is high;
  // that cycle transfers fbuff_data_i (same-cycle response allowed) and the request drops next cycle.
  logic                               fetch_req_i;
  logic [$clog2(TILE_LNS)-1:0]        tile_ln_i;
  logic [$clog2(NUM_BUFFS)-1:0]       buff_id_i;
  logic                               fetch_busy_o;
  logic                               fetch_done_o;
  logic                               fetch_err_o;
  logic                               fbuff_rd_req_o;
  logic                               fbuff_rd_rsp_i;
  logic [FBUFF_ADDR_WIDTH-1:0]        fbuff_addr_o;
  logic [FBUFF_DATA_WIDTH-1:0]        fbuff_data_i;
  logic [NUM_BUFFS-1:0]               lbuff_wen_o;
  logic [$clog2(TILE_PER_LINE)-1:0]   lbuff_addr_o;
  logic [PXL_WIDTH-1:0]               lbuff_data_o;
  logic [1:0]                         dbg_state_o;

  modport master (
    input  fetch_req_i, tile_ln_i, buff_id_i, fbuff_rd_rsp_i, fbuff_data_i,
    output fetch_busy_o, fetch_done_o, fetch_err_o, fbuff_rd_req_o, fbuff_addr_o,
           lbuff_wen_o, lbuff_addr_o, lbuff_data_o, dbg_state_o
  );

  modport slave (
    output fetch_req_i, tile_ln_i, buff_id_i, fbuff_rd_rsp_i, fbuff_data_i,
    input  fetch_busy_o, fetch_done_o, fetch_err_o, fbuff_rd_req_o, fbuff_addr_o,
           lbuff_wen_o, lbuff_addr_o, lbuff_data_o, dbg_state_o
  );
endinterface

// File: rtl/line_fetch_ctrl.sv
// Line-buffer fill engine: reads one tile-line from the frame buffer row by row and unpacks it into one of N line buffers.
// Optional read-response watchdog enabled by defining LINE_FETCH_TIMEOUT_EN.
module line_fetch_ctrl #(
  parameter int PXL_WIDTH        = 12,
  parameter int TILE_WIDTH       = 4,
  parameter int WIDTH_PX         = 640,
  parameter int HEIGHT_LNS       = 480,
  parameter int TILE_PER_ROW     = 4,
  parameter int NUM_BUFFS        = 2,
  parameter int FBUFF_ADDR_WIDTH = 13,
  parameter int TIMEOUT_CYC      = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  line_fetch_ctrl_if.master    bus
);
  localparam int TILE_PER_LINE    = WIDTH_PX / TILE_WIDTH;
  localparam int ROWS_PER_LINE    = TILE_PER_LINE / TILE_PER_ROW;
  localparam int TILE_LNS         = HEIGHT_LNS / TILE_WIDTH;
  localparam int FBUFF_DATA_WIDTH = TILE_PER_ROW * PXL_WIDTH;
  localparam int BUFF_W           = $clog2(NUM_BUFFS);
  localparam int LADDR_W          = $clog2(TILE_PER_LINE);
  localparam int ROW_W            = (ROWS_PER_LINE > 1) ? $clog2(ROWS_PER_LINE) : 1;
  localparam int K_W              = (TILE_PER_ROW > 1) ? $clog2(TILE_PER_ROW) : 1;
  // An illegal parameter set leaves the engine permanently idle rather than writing garbage.
  localparam bit CFG_OK = (TILE_PER_LINE % TILE_PER_ROW == 0) && (NUM_BUFFS >= 2) &&
                          (NUM_BUFFS <= 4) && (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_UNPK = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                      r_state;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_rd_req;
  logic [FBUFF_ADDR_WIDTH-1:0] r_addr;
  logic [BUFF_W-1:0]           r_buff;
  logic [ROW_W-1:0]            r_row;
  logic [K_W-1:0]              r_k;
  logic [LADDR_W-1:0]          r_tile;
  logic [FBUFF_DATA_WIDTH-1:0] r_shift;
  logic [NUM_BUFFS-1:0]        r_wen;
  logic [LADDR_W-1:0]          r_laddr;
  logic [PXL_WIDTH-1:0]        r_ldata;
`ifdef LINE_FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0]           r_wait;
  logic                        r_err;
`endif

  logic                        w_accept;
  logic [FBUFF_ADDR_WIDTH-1:0] w_base;
  logic [NUM_BUFFS-1:0]        w_wen_onehot;

  assign w_accept     = CFG_OK && bus.fetch_req_i &&
                        (int'(bus.tile_ln_i) < TILE_LNS) && (int'(bus.buff_id_i) < NUM_BUFFS);
  assign w_base       = FBUFF_ADDR_WIDTH'(int'(bus.tile_ln_i) * ROWS_PER_LINE);
  assign w_wen_onehot = NUM_BUFFS'(1) << r_buff;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_rd_req <= 1'b0;
      r_addr   <= '0;
      r_buff   <= '0;
      r_row    <= '0;
      r_k      <= '0;
      r_tile   <= '0;
      r_shift  <= '0;
      r_wen    <= '0;
      r_laddr  <= '0;
      r_ldata  <= '0;
`ifdef LINE_FETCH_TIMEOUT_EN
      r_wait   <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_done  <= 1'b0;
      r_wen   <= '0;
      r_laddr <= '0;
      r_ldata <= '0;
`ifdef LINE_FETCH_TIMEOUT_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_buff   <= bus.buff_id_i;
            r_addr   <= w_base;
            r_row    <= '0;
            r_tile   <= '0;
            r_busy   <= 1'b1;
            r_rd_req <= 1'b1;
`ifdef LINE_FETCH_TIMEOUT_EN
            r_wait   <= '0;
`endif
            r_state  <= S_RD;
          end
        end
        S_RD: begin
          if (bus.fbuff_rd_rsp_i) begin
            // Tile 0 goes straight out; the rest are shifted down one per cycle.
            r_rd_req <= 1'b0;
            r_shift  <= bus.fbuff_data_i >> PXL_WIDTH;
            r_wen    <= w_wen_onehot;
            r_laddr  <= r_tile;
            r_ldata  <= bus.fbuff_data_i[PXL_WIDTH-1:0];
            r_tile   <= r_tile + LADDR_W'(1);
            r_k      <= '0;
            r_state  <= S_UNPK;
          end
`ifdef LINE_FETCH_TIMEOUT_EN
          else if (r_wait == WAIT_W'(TIMEOUT_CYC - 1)) begin
            r_rd_req <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_wait   <= r_wait + WAIT_W'(1);
          end
`endif
        end
        S_UNPK: begin
          if (r_k == K_W'(TILE_PER_ROW - 1)) begin
            if (r_row == ROW_W'(ROWS_PER_LINE - 1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_row    <= r_row + ROW_W'(1);
              r_addr   <= r_addr + FBUFF_ADDR_WIDTH'(1);
              r_rd_req <= 1'b1;
`ifdef LINE_FETCH_TIMEOUT_EN
              r_wait   <= '0;
`endif
              r_state  <= S_RD;
            end
          end else begin
            r_k     <= r_k + K_W'(1);
            r_wen   <= w_wen_onehot;
            r_laddr <= r_tile;
            r_ldata <= r_shift[PXL_WIDTH-1:0];
            r_shift <= r_shift >> PXL_WIDTH;
            r_tile  <= r_tile + LADDR_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Address is only meaningful while a read is outstanding.
  assign bus.fetch_busy_o   = r_busy;
  assign bus.fetch_done_o   = r_done;
  assign bus.fbuff_rd_req_o = r_rd_req;
  assign bus.fbuff_addr_o   = r_rd_req ? r_addr : '0;
  assign bus.lbuff_wen_o    = r_wen;
  assign bus.lbuff_addr_o   = r_laddr;
  assign bus.lbuff_data_o   = r_ldata;
  assign bus.dbg_state_o    = r_state;
`ifdef LINE_FETCH_TIMEOUT_EN
  assign bus.fetch_err_o    = r_err;
`else
  assign bus.fetch_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Directed bench for line_fetch_ctrl: vector table of whole-line fetches plus reset, busy and timeout sequences.
module tb_line_fetch_ctrl;
  localparam int ROWS = 40;
  localparam int TPL  = 160;
  localparam int W    = 20;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  line_fetch_ctrl_if bus ();

  line_fetch_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- frame-buffer responder
  int rsp_delay = 0;
  int hold_addr = -1;
  int wait_cnt  = 0;

  function automatic logic [47:0] row_pat(input int a);
    logic [47:0] v;
    for (int k = 0; k < 4; k++) v[k*12 +: 12] = 12'(a * 4 + k);
    return v;
  endfunction

  assign bus.fbuff_rd_rsp_i = bus.fbuff_rd_req_o && (wait_cnt >= rsp_delay) &&
                              (int'(bus.fbuff_addr_o) != hold_addr);
  assign bus.fbuff_data_i   = bus.fbuff_rd_rsp_i ? row_pat(int'(bus.fbuff_addr_o)) : 48'hbad0_bad0_bad0;

  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (!bus.fbuff_rd_req_o || bus.fbuff_rd_rsp_i) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  // ---------------- scoreboard
  logic [W-1:0]  exp_q[$];
  logic [12:0]   exp_addr_q[$];
  logic [1:0]    cur_wen = 2'b01;
  int            first_addr = -1;
  int            done_cnt = 0, err_cnt = 0, issue_cnt = 0;
  int            done_cyc = 0, req_cyc = 0;
  int            rd_run = 0, last_run = 0;
  logic          prev_rd_req = 1'b0, prev_rsp = 1'b0;
  logic [12:0]   prev_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=unexpected required=none (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_rd_req = 1'b0;
      prev_rsp    = 1'b0;
      rd_run      = 0;
    end else begin
      if (bus.fbuff_rd_req_o) rd_run++;
      else begin
        if (prev_rd_req) last_run = rd_run;
        rd_run = 0;
      end
      if (bus.fbuff_rd_req_o && !prev_rd_req) issue_cnt++;
      if (bus.fbuff_rd_req_o && prev_rd_req && !prev_rsp)
        chk("rd_addr_stable", bus.fbuff_addr_o, prev_addr);
      if (bus.fbuff_rd_req_o && bus.fbuff_rd_rsp_i) begin
        if (first_addr < 0) first_addr = int'(bus.fbuff_addr_o);
        if (exp_addr_q.size() == 0) fail_now("rd_addr_extra");
        else chk("rd_addr", bus.fbuff_addr_o, exp_addr_q.pop_front());
      end
      if (bus.fetch_done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.fetch_err_o) err_cnt++;
      if (bus.lbuff_wen_o != '0) begin
        chk("lbuff_wen", bus.lbuff_wen_o, cur_wen);
        if (exp_q.size() == 0) fail_now("lbuff_write_extra");
        else chk("lbuff_write", {bus.lbuff_addr_o, bus.lbuff_data_o}, exp_q.pop_front());
      end else begin
        chk("lbuff_idle_zero", {bus.lbuff_addr_o, bus.lbuff_data_o}, '0);
      end
      prev_rd_req = bus.fbuff_rd_req_o;
      prev_rsp    = bus.fbuff_rd_rsp_i;
      prev_addr   = bus.fbuff_addr_o;
    end
  end

  // ---------------- driver tasks
  task automatic issue(input int tl, input int bid, input int model_rows);
    for (int r = 0; r < model_rows; r++) exp_addr_q.push_back(13'(tl * ROWS + r));
    for (int t = 0; t < model_rows * 4; t++) exp_q.push_back({8'(t), 12'(tl * TPL + t)});
    if (model_rows > 0) cur_wen = 2'(1 << bid);
    first_addr = -1;
    @(negedge clk);
    bus.fetch_req_i = 1'b1;
    bus.tile_ln_i   = 7'(tl);
    bus.buff_id_i   = 1'(bid);
    req_cyc         = cyc;
    @(negedge clk);
    bus.fetch_req_i = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit, output bit ok);
    int n;
    n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = (done_cnt != d0);
    chk("done_seen", ok, 1'b1);
  endtask

  task automatic check_line(input string name, input int d0, input int i0,
                            input int exp_lat, input int exp_first);
    chk({name, "_latency"}, done_cyc - req_cyc, exp_lat);
    chk({name, "_first_addr"}, first_addr, exp_first);
    chk({name, "_rd_issues"}, issue_cnt - i0, ROWS);
    chk({name, "_writes_left"}, exp_q.size(), 0);
    chk({name, "_addrs_left"}, exp_addr_q.size(), 0);
    @(negedge clk);
    chk({name, "_done_pulse"}, {bus.fetch_done_o, bus.fetch_busy_o}, 2'b00);
    chk({name, "_done_count"}, done_cnt - d0, 1);
  endtask

  // ---------------- stimulus table
  typedef struct {
    int         tile_ln;
    int         buff;
    int         dly;
    bit         accept;
    int         exp_first;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit ok;
    int d0, i0, n;

    vecs[0] = '{0,   0, 0, 1'b1, 0,    201};
    vecs[1] = '{119, 1, 3, 1'b1, 4760, 321};
    vecs[2] = '{120, 0, 0, 1'b0, 0,    0};
    vecs[3] = '{60,  1, 1, 1'b1, 2400, 241};
    vecs[4] = '{127, 1, 0, 1'b0, 0,    0};
    vecs[5] = '{1,   0, 2, 1'b1, 40,   281};

    rst             = 1'b1;
    bus.fetch_req_i = 1'b0;
    bus.tile_ln_i   = '0;
    bus.buff_id_i   = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.fetch_busy_o, bus.fetch_done_o, bus.fetch_err_o, bus.fbuff_rd_req_o,
        bus.fbuff_addr_o, bus.lbuff_wen_o, bus.lbuff_addr_o, bus.lbuff_data_o, bus.dbg_state_o}, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      i0 = issue_cnt;
      rsp_delay = vecs[i].dly;
      issue(vecs[i].tile_ln, vecs[i].buff, vecs[i].accept ? ROWS : 0);
      if (vecs[i].accept) begin
        wait_done(d0, 1000, ok);
        if (ok) check_line($sformatf("vec%0d", i), d0, i0, vecs[i].exp_lat, vecs[i].exp_first);
      end else begin
        repeat (5) @(negedge clk);
        chk($sformatf("vec%0d_ignored", i), {bus.fetch_busy_o, bus.dbg_state_o}, 3'b000);
        chk($sformatf("vec%0d_no_rd", i), issue_cnt - i0, 0);
      end
      repeat (2) @(negedge clk);
    end

    // request while busy must be dropped
    rsp_delay = 0;
    d0 = done_cnt;
    i0 = issue_cnt;
    issue(2, 0, ROWS);
    repeat (50) @(negedge clk);
    bus.fetch_req_i = 1'b1;
    bus.tile_ln_i   = 7'd7;
    bus.buff_id_i   = 1'b1;
    @(negedge clk);
    bus.fetch_req_i = 1'b0;
    wait_done(d0, 1000, ok);
    if (ok) check_line("busy_drop", d0, i0, 201, 80);
    i0 = issue_cnt;
    repeat (10) @(negedge clk);
    chk("busy_drop_no_extra_rd", issue_cnt - i0, 0);
    chk("busy_drop_idle", bus.fetch_busy_o, 1'b0);

    // asynchronous reset in the middle of row 10
    issue(0, 0, ROWS);
    n = 0;
    while (!(bus.fbuff_rd_req_o && bus.fbuff_addr_o == 13'd10) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_row10", bus.fbuff_addr_o, 13'd10);
    #2 rst = 1'b1;
    #1;
    chk("midfetch_reset_outputs", {bus.fetch_busy_o, bus.fetch_done_o, bus.fetch_err_o, bus.fbuff_rd_req_o,
        bus.fbuff_addr_o, bus.lbuff_wen_o, bus.lbuff_addr_o, bus.lbuff_data_o, bus.dbg_state_o}, '0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    d0 = done_cnt;
    i0 = issue_cnt;
    issue(5, 1, ROWS);
    wait_done(d0, 1000, ok);
    if (ok) check_line("after_reset", d0, i0, 201, 200);

`ifdef LINE_FETCH_TIMEOUT_EN
    // response withheld at row 3 of tile-line 8
    d0 = done_cnt;
    i0 = err_cnt;
    hold_addr = 8 * ROWS + 3;
    issue(8, 1, 3);
    n = 0;
    while (err_cnt == i0 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("timeout_err_seen", err_cnt - i0, 1);
    chk("timeout_wait_cycles", last_run, 64);
    chk("timeout_no_done", done_cnt - d0, 0);
    chk("timeout_writes_left", exp_q.size(), 0);
    chk("timeout_busy", bus.fetch_busy_o, 1'b0);
    @(negedge clk);
    chk("timeout_err_pulse", bus.fetch_err_o, 1'b0);
    hold_addr = -1;
    d0 = done_cnt;
    i0 = issue_cnt;
    issue(9, 0, ROWS);
    wait_done(d0, 1000, ok);
    if (ok) check_line("after_timeout", d0, i0, 201, 360);
`else
    chk("no_err_pulses", err_cnt, 0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
